// File: rtl/udp_axis_rx_buffer_if.sv
// AXI-Stream bundle used on both sides of the receive buffer.
//   Transmitter : drives tvalid/tdata/tkeep/tstrb/tlast/tid/tdest/tuser/twakeup,
//                 samples tready.
//   Receiver    : the mirror image; drives tready.
// tkeep/tstrb carry one bit per tdata byte.
interface AXIS_IF #(
   parameter int TDATA_WIDTH = 8,
   parameter int TID_WIDTH   = 8,
   parameter int TDEST_WIDTH = 8,
   parameter int TUSER_WIDTH = 1
) ();
   logic                       tvalid;
   logic                       tready;
   logic [TDATA_WIDTH-1:0]     tdata;
   logic [TDATA_WIDTH/8-1:0]   tkeep;
   logic [TDATA_WIDTH/8-1:0]   tstrb;
   logic                       tlast;
   logic [TID_WIDTH-1:0]       tid;
   logic [TDEST_WIDTH-1:0]     tdest;
   logic [TUSER_WIDTH-1:0]     tuser;
   logic                       twakeup;

   modport Transmitter (
      output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, twakeup,
      input  tready
   );

   modport Receiver (
      input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, twakeup,
      output tready
   );
endinterface

// File: rtl/udp_axis_rx_buffer.sv
// Receive buffer behind the UDP-to-AXI-Stream receiver.
// Bytes from the 8-bit input stream are stored as {tlast, tdata} in a
// first-word-fall-through FIFO (synchronous RAM plus a head register) and are
// packed little-endian into OUT_WIDTH-bit output words. A word is closed when
// all lanes are filled or when a byte carrying tlast arrives, so packets never
// share an output word.
// Ports:
//   clk, reset  : single clock, synchronous active-high reset
//   s_axis_if   : 8-bit byte stream in (tvalid/tdata/tlast used, tready driven)
//   m_axis_if   : OUT_WIDTH-bit packed stream out (tstrb mirrors tkeep)
//   fifo_level  : bytes held in RAM + head register (packer bytes excluded)
module udp_axis_rx_buffer #(
   parameter int FIFO_DEPTH = 4096,
   parameter int OUT_WIDTH  = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   AXIS_IF.Receiver                      s_axis_if,
   AXIS_IF.Transmitter                   m_axis_if,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int BYTES = OUT_WIDTH / 8;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LW    = AW + 1;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [LW-1:0]    HALF     = LW'(FIFO_DEPTH / 2);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

   typedef enum logic [0:0] {
      STATE_FILL   = 1'b0,
      STATE_OUTPUT = 1'b1
   } state_t;

   // FIFO storage and pointers
   logic [8:0]       mem [0:FIFO_DEPTH-1];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [8:0]       head_q;
   logic             head_valid;
   logic             push;
   logic             pop;
   logic             ram_has_data;
   logic             rd_en;

   // Packer state
   state_t               state, state_next;
   logic [IDX_W-1:0]     idx, idx_next;
   logic [OUT_WIDTH-1:0] acc_data, acc_data_next;
   logic [BYTES-1:0]     acc_keep, acc_keep_next;
   logic [OUT_WIDTH-1:0] out_data, out_data_next;
   logic [BYTES-1:0]     out_keep, out_keep_next;
   logic                 out_last, out_last_next;
   logic                 out_valid, out_valid_next;
   logic [OUT_WIDTH-1:0] lane_data, merged_data;
   logic [BYTES-1:0]     lane_keep, merged_keep;

   // Reset term keeps tready low while the block is being cleared, even
   // though the level register only clears at the next edge.
   assign s_axis_if.tready = !reset && (fifo_level < HALF);
   assign push             = s_axis_if.tvalid && s_axis_if.tready;

   // Entries still in RAM = level minus the head register.
   assign ram_has_data = fifo_level > LW'(head_valid);
   assign rd_en        = ram_has_data && (!head_valid || pop);

   // RAM write port and registered read into the head
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {s_axis_if.tlast, s_axis_if.tdata};
      end
      if (rd_en) begin
         head_q <= mem[rd_ptr];
      end
   end

   // FIFO pointers, head-valid flag and byte level
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         head_valid <= 1'b0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr     <= rd_ptr + AW'(1);
            head_valid <= 1'b1;
         end else if (pop) begin
            head_valid <= 1'b0;
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Packer FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= STATE_FILL;
      end else begin
         state <= state_next;
      end
   end

   // Packer next-state, pop control and datapath next values
   always_comb begin
      state_next     = state;
      pop            = 1'b0;
      idx_next       = idx;
      acc_data_next  = acc_data;
      acc_keep_next  = acc_keep;
      out_data_next  = out_data;
      out_keep_next  = out_keep;
      out_last_next  = out_last;
      out_valid_next = out_valid;
      lane_data      = '0;
      lane_keep      = '0;
      for (int b = 0; b < BYTES; b++) begin
         lane_data[8*b +: 8] = (idx == IDX_W'(b)) ? head_q[7:0] : 8'h00;
         lane_keep[b]        = (idx == IDX_W'(b));
      end
      merged_data = acc_data | lane_data;
      merged_keep = acc_keep | lane_keep;

      case (state)
         STATE_FILL: begin
            if (head_valid) begin
               pop = 1'b1;
               // head_q[8] is the stored tlast
               if ((idx == LAST_IDX) || head_q[8]) begin
                  out_data_next  = merged_data;
                  out_keep_next  = merged_keep;
                  out_last_next  = head_q[8];
                  out_valid_next = 1'b1;
                  acc_data_next  = '0;
                  acc_keep_next  = '0;
                  idx_next       = '0;
                  state_next     = STATE_OUTPUT;
               end else begin
                  acc_data_next = merged_data;
                  acc_keep_next = merged_keep;
                  idx_next      = idx + IDX_W'(1);
               end
            end else begin
               state_next = STATE_FILL;
            end
         end
         STATE_OUTPUT: begin
            if (m_axis_if.tready) begin
               out_valid_next = 1'b0;
               state_next     = STATE_FILL;
            end else begin
               state_next = STATE_OUTPUT;
            end
         end
         default: begin
            out_valid_next = 1'b0;
            state_next     = STATE_FILL;
         end
      endcase
   end

   // Accumulator and output register
   always_ff @(posedge clk) begin
      if (reset) begin
         idx       <= '0;
         acc_data  <= '0;
         acc_keep  <= '0;
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         idx       <= idx_next;
         acc_data  <= acc_data_next;
         acc_keep  <= acc_keep_next;
         out_data  <= out_data_next;
         out_keep  <= out_keep_next;
         out_last  <= out_last_next;
         out_valid <= out_valid_next;
      end
   end

   assign m_axis_if.tvalid  = out_valid;
   assign m_axis_if.tdata   = out_data;
   assign m_axis_if.tkeep   = out_keep;
   assign m_axis_if.tstrb   = out_keep;
   assign m_axis_if.tlast   = out_last;
   assign m_axis_if.tid     = '0;
   assign m_axis_if.tdest   = '0;
   assign m_axis_if.tuser   = '0;
   assign m_axis_if.twakeup = 1'b0;

endmodule

// File: tb/tb_udp_axis_rx_buffer.sv
// Directed self-checking bench for udp_axis_rx_buffer (FIFO_DEPTH=4096,
// OUT_WIDTH=32). Inputs change 1 ns after the rising edge; outputs are
// sampled there or on the falling edge.
module tb_udp_axis_rx_buffer;
   localparam int FIFO_DEPTH = 4096;
   localparam int OUT_WIDTH  = 32;
   localparam int LW         = 13;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [LW-1:0] fifo_level;

   AXIS_IF #(.TDATA_WIDTH(8))  s_axis_if ();
   AXIS_IF #(.TDATA_WIDTH(32)) m_axis_if ();

   udp_axis_rx_buffer #(.FIFO_DEPTH(FIFO_DEPTH), .OUT_WIDTH(OUT_WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .s_axis_if  (s_axis_if),
      .m_axis_if  (m_axis_if),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int accepted = 0;

   logic [8:0]  tx_q [$];
   logic [36:0] got_q [$];
   logic [36:0] exp_q [$];
   logic        prev_stall = 1'b0;
   logic [37:0] prev_out   = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: capture handshakes, and check that a stalled word holds.
   always @(negedge clk) begin
      if (reset) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold", {m_axis_if.tvalid, m_axis_if.tlast, m_axis_if.tkeep, m_axis_if.tdata}, prev_out);
         end
         if (m_axis_if.tvalid && m_axis_if.tready) begin
            got_q.push_back({m_axis_if.tlast, m_axis_if.tkeep, m_axis_if.tdata});
         end
         prev_stall <= m_axis_if.tvalid && !m_axis_if.tready;
         prev_out   <= {m_axis_if.tvalid, m_axis_if.tlast, m_axis_if.tkeep, m_axis_if.tdata};
      end
   end

   // Queue n bytes seed, seed+1, ...; tlast on the final byte when with_last.
   task automatic queue_bytes(input int n, input logic [7:0] seed, input bit with_last);
      for (int i = 0; i < n; i++) begin
         tx_q.push_back({(with_last && (i == n - 1)), 8'(seed + 8'(i))});
      end
   endtask

   // Reference packing of one packet: little-endian, 4 lanes, close on tlast.
   task automatic model_pkt(input int n, input logic [7:0] seed);
      logic [31:0] w;
      logic [3:0]  k;
      int          lane;
      logic        last;
      w = '0; k = '0; lane = 0;
      for (int i = 0; i < n; i++) begin
         last = (i == n - 1);
         w[8*lane +: 8] = 8'(seed + 8'(i));
         k[lane] = 1'b1;
         if (lane == 3 || last) begin
            exp_q.push_back({last, k, w});
            w = '0; k = '0; lane = 0;
         end else begin
            lane++;
         end
      end
   endtask

   task automatic send_all();
      logic hs;
      int   t;
      while (tx_q.size() > 0) begin
         s_axis_if.tvalid = 1'b1;
         s_axis_if.tdata  = tx_q[0][7:0];
         s_axis_if.tlast  = tx_q[0][8];
         hs = 1'b0;
         t  = 0;
         while (!hs && t < 5000) begin
            hs = s_axis_if.tready;
            tick();
            t++;
         end
         if (!hs) begin
            check("tx_wait", hs, 1'b1);
            tx_q.delete();
         end else begin
            void'(tx_q.pop_front());
            accepted++;
         end
      end
      s_axis_if.tvalid = 1'b0;
      s_axis_if.tlast  = 1'b0;
   endtask

   task automatic compare_words(input string tag, input int limit);
      int t;
      int n;
      t = 0;
      while (got_q.size() < exp_q.size() && t < limit) begin
         tick();
         t++;
      end
      repeat (3) tick();
      check({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int cyc;
      s_axis_if.tvalid  = 1'b0;
      s_axis_if.tdata   = 8'h00;
      s_axis_if.tlast   = 1'b0;
      s_axis_if.tkeep   = 1'b0;
      s_axis_if.tstrb   = 1'b0;
      s_axis_if.tid     = 8'h00;
      s_axis_if.tdest   = 8'h00;
      s_axis_if.tuser   = 1'b0;
      s_axis_if.twakeup = 1'b0;
      m_axis_if.tready  = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_s_tready", s_axis_if.tready, 1'b0);
      check("rst_level", fifo_level, 13'd0);
      check("rst_tvalid", m_axis_if.tvalid, 1'b0);
      check("rst_tdata", m_axis_if.tdata, 32'h0);
      check("rst_tkeep", m_axis_if.tkeep, 4'h0);
      check("rst_tlast", m_axis_if.tlast, 1'b0);
      reset = 1'b0;
      #1;
      check("rel_s_tready", s_axis_if.tready, 1'b1);
      tick();

      // Single byte 0xA5 with tlast: latency to tvalid is two edges
      m_axis_if.tready = 1'b1;
      s_axis_if.tvalid = 1'b1;
      s_axis_if.tdata  = 8'hA5;
      s_axis_if.tlast  = 1'b1;
      tick();                                  // edge E
      s_axis_if.tvalid = 1'b0;
      s_axis_if.tlast  = 1'b0;
      check("t1_level_e", fifo_level, 13'd1);
      check("t1_tvalid_e", m_axis_if.tvalid, 1'b0);
      tick();                                  // edge E+1
      check("t1_tvalid_e1", m_axis_if.tvalid, 1'b0);
      check("t1_level_e1", fifo_level, 13'd1);
      tick();                                  // edge E+2
      check("t1_tvalid_e2", m_axis_if.tvalid, 1'b1);
      check("t1_tdata", m_axis_if.tdata, 32'h000000A5);
      check("t1_tkeep", m_axis_if.tkeep, 4'b0001);
      check("t1_tlast", m_axis_if.tlast, 1'b1);
      check("t1_tstrb", m_axis_if.tstrb, 4'b0001);
      check("t1_level_e2", fifo_level, 13'd0);
      exp_q.push_back({1'b1, 4'h1, 32'h000000A5});
      compare_words("t1", 20);
      check("t1_tvalid_done", m_axis_if.tvalid, 1'b0);

      // Ten-byte packet 0x01..0x0A
      queue_bytes(10, 8'h01, 1'b1);
      exp_q.push_back({1'b0, 4'hF, 32'h04030201});
      exp_q.push_back({1'b0, 4'hF, 32'h08070605});
      exp_q.push_back({1'b1, 4'h3, 32'h00000A09});
      send_all();
      compare_words("t2", 100);

      // Back-to-back packets of 5 and 3 bytes
      queue_bytes(5, 8'h11, 1'b1);
      queue_bytes(3, 8'h21, 1'b1);
      exp_q.push_back({1'b0, 4'hF, 32'h14131211});
      exp_q.push_back({1'b1, 4'h1, 32'h00000015});
      exp_q.push_back({1'b1, 4'h7, 32'h00232221});
      send_all();
      compare_words("t4", 100);

      // Fill to half with the output stalled. The first word sits in the
      // output register, so 2048 + 4 bytes are accepted before tready drops.
      m_axis_if.tready = 1'b0;
      accepted = 0;
      queue_bytes(2060, 8'h40, 1'b1);
      model_pkt(2060, 8'h40);
      fork
         send_all();
         begin
            cyc = 0;
            while (fifo_level != 13'd2048 && cyc < 4000) begin
               tick();
               cyc++;
            end
            check("t3_level_half", fifo_level, 13'd2048);
            repeat (20) tick();
            check("t3_level_hold", fifo_level, 13'd2048);
            check("t3_s_tready_low", s_axis_if.tready, 1'b0);
            check("t3_accepted", accepted, 2052);
            m_axis_if.tready = 1'b1;
            cyc = 0;
            while (!s_axis_if.tready && cyc < 100) begin
               tick();
               cyc++;
            end
            check("t3_s_tready_back", s_axis_if.tready, 1'b1);
            check("t3_level_back", fifo_level, 13'd2047);
         end
      join
      compare_words("t3", 10000);
      check("t3_level_empty", fifo_level, 13'd0);

      // 64-byte packet with m tready toggling randomly
      queue_bytes(64, 8'hB0, 1'b1);
      model_pkt(64, 8'hB0);
      fork
         send_all();
         begin
            cyc = 0;
            while (got_q.size() < 16 && cyc < 4000) begin
               tick();
               m_axis_if.tready = 1'($urandom_range(0, 1));
               cyc++;
            end
            m_axis_if.tready = 1'b1;
         end
      join
      compare_words("t5", 200);

      // Reset with 100 bytes buffered (4 more sit in the output register)
      m_axis_if.tready = 1'b0;
      queue_bytes(104, 8'h60, 1'b0);
      send_all();
      repeat (3) tick();
      check("t6_level_pre", fifo_level, 13'd100);
      check("t6_tvalid_pre", m_axis_if.tvalid, 1'b1);
      reset = 1'b1;
      #1;
      check("t6_s_tready_rst", s_axis_if.tready, 1'b0);
      tick();
      check("t6_level_rst", fifo_level, 13'd0);
      check("t6_tvalid_rst", m_axis_if.tvalid, 1'b0);
      check("t6_tkeep_rst", m_axis_if.tkeep, 4'h0);
      tick();
      reset = 1'b0;
      #1;
      check("t6_s_tready_rel", s_axis_if.tready, 1'b1);
      tick();
      check("t6_level_rel", fifo_level, 13'd0);
      check("t6_tvalid_rel", m_axis_if.tvalid, 1'b0);
      got_q.delete();
      exp_q.delete();
      m_axis_if.tready = 1'b1;
      queue_bytes(6, 8'hC1, 1'b1);
      exp_q.push_back({1'b0, 4'hF, 32'hC4C3C2C1});
      exp_q.push_back({1'b1, 4'h3, 32'h0000C6C5});
      send_all();
      compare_words("t6", 100);
      check("t6_level_end", fifo_level, 13'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
